// File: rtl/sm_result_encoder_if.sv
// rtl/sm_result_encoder_if.sv - result handshake bundle between adder side, encoder and consumer
interface sm_result_encoder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_carry;
  logic                  in_overflow;
  logic                  in_fmt;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_carry;
  logic                  out_overflow;
  logic                  out_unrep;

  modport slave (
    input  in_valid, in_data, in_carry, in_overflow, in_fmt, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_overflow, out_unrep
  );

  modport master (
    output in_valid, in_data, in_carry, in_overflow, in_fmt, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_overflow, out_unrep
  );
endinterface

// File: rtl/sm_result_encoder.sv
// rtl/sm_result_encoder.sv - 2's-complement to sign-magnitude re-encoder with 2-entry result FIFO
// Optional transfer counter enabled by defining SMENC_STATS_EN.
module sm_result_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sm_result_encoder_if.slave   bus,
  output logic [CNT_WIDTH-1:0] stat_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  carry;
    logic                  overflow;
    logic                  unrep;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-2:0] LOW_ONE  = {{(DATA_WIDTH-2){1'b0}}, 1'b1};

  occ_t   state, state_nxt;
  entry_t mem [2];
  entry_t enc;
  entry_t hold;
  entry_t head;
  logic   wr_ptr, rd_ptr;
  logic   push, pop;
  logic [DATA_WIDTH-2:0] mag;

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Only the low W-1 bits of the negation are ever stored, so negate just those.
  always_comb begin
    mag          = ~bus.in_data[DATA_WIDTH-2:0] + LOW_ONE;
    enc.data     = bus.in_data;
    enc.carry    = bus.in_carry;
    enc.overflow = bus.in_overflow;
    enc.unrep    = 1'b0;
    if (bus.in_fmt && bus.in_data[DATA_WIDTH-1]) begin
      if (bus.in_data == MOST_NEG) begin
        enc.data  = '1;
        enc.unrep = 1'b1;
      end else begin
        enc.data = {1'b1, mag};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (!push && pop) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      hold   <= '0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        hold   <= mem[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // When drained, keep showing the last delivered entry instead of the stale slot.
  assign head             = (state == EMPTY) ? hold : mem[rd_ptr];
  assign bus.out_data     = head.data;
  assign bus.out_carry    = head.carry;
  assign bus.out_overflow = head.overflow;
  assign bus.out_unrep    = head.unrep;

`ifdef SMENC_STATS_EN
  logic [CNT_WIDTH-1:0] cnt;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (pop && (cnt != '1)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign stat_count = cnt;
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_sm_result_encoder.sv
// tb/tb_sm_result_encoder.sv - scoreboard bench for sm_result_encoder
module tb_sm_result_encoder;
  localparam int W  = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0] stat_count;

  always #5 clk = ~clk;

  sm_result_encoder_if #(.DATA_WIDTH(W)) bus ();

  sm_result_encoder #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stat_count (stat_count)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         ovf;
    logic         unrep;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;
  bit   armed   = 1'b0;

  function automatic exp_t model(logic [W-1:0] d, logic c, logic o, logic f);
    exp_t         e;
    logic [W-1:0] m;
    e.data  = d;
    e.carry = c;
    e.ovf   = o;
    e.unrep = 1'b0;
    if (f && d[W-1]) begin
      if (d == 8'h80) begin
        e.data  = 8'hFF;
        e.unrep = 1'b1;
      end else begin
        m      = -d;
        e.data = {1'b1, m[W-2:0]};
      end
    end
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [W-1:0] d, logic c, logic o, logic f);
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_carry    = c;
    bus.in_overflow = o;
    bus.in_fmt      = f;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && (sb.size() != 0 || bus.out_valid); i++) step();
    check("drain_sb_empty", 32'(sb.size()), 0);
    check("drain_out_valid", 32'(bus.out_valid), 0);
  endtask

  // Monitor: push model results on accept, pop and compare on transfer.
  always @(negedge clk) begin
    if (armed) begin
      check("stat_count", 32'(stat_count), 32'(exp_cnt));
      if (rst) begin
        sb.delete();
        exp_cnt = 0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          check("sb_has_entry", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", 32'(bus.out_data), 32'(e.data));
            check("out_carry", 32'(bus.out_carry), 32'(e.carry));
            check("out_overflow", 32'(bus.out_overflow), 32'(e.ovf));
            check("out_unrep", 32'(bus.out_unrep), 32'(e.unrep));
          end
`ifdef SMENC_STATS_EN
          if (exp_cnt < (1 << CW) - 1) exp_cnt++;
`endif
        end
        if (bus.in_valid && bus.in_ready)
          sb.push_back(model(bus.in_data, bus.in_carry, bus.in_overflow, bus.in_fmt));
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_carry    = 1'b0;
    bus.in_overflow = 1'b0;
    bus.in_fmt      = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_carry", 32'(bus.out_carry), 0);
    check("rst_out_overflow", 32'(bus.out_overflow), 0);
    check("rst_out_unrep", 32'(bus.out_unrep), 0);
    step();

    // Encoding and one-cycle latency
    bus.out_ready = 1'b1;
    drive(8'hFB, 1'b0, 1'b1, 1'b1);
    check("latency_out_valid", 32'(bus.out_valid), 1);
    check("neg5_sm", 32'(bus.out_data), 32'h85);
    drive(8'h80, 1'b1, 1'b0, 1'b1);
    check("most_neg_sat", 32'(bus.out_data), 32'hFF);
    check("most_neg_unrep", 32'(bus.out_unrep), 1);
    drive(8'h7F, 1'b0, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    check("zero_not_neg", 32'(bus.out_data), 32'h00);
    drive(8'hFB, 1'b1, 1'b0, 1'b0);
    check("fmt0_pass", 32'(bus.out_data), 32'hFB);
    wait_drain();

    // Backpressure: third value refused while full
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_fmt      = 1'b0;
    bus.in_carry    = 1'b0;
    bus.in_overflow = 1'b0;
    bus.in_data     = 8'h01;
    step();
    bus.in_data = 8'h02;
    step();
    check("full_in_ready", 32'(bus.in_ready), 0);
    bus.in_data = 8'h03;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("full_hold_in_ready", 32'(bus.in_ready), 0);
    check("full_head", 32'(bus.out_data), 32'h01);
    step();
    check("ready_after_pop", 32'(bus.in_ready), 1);
    check("second_head", 32'(bus.out_data), 32'h02);
    step();
    check("third_not_taken", 32'(bus.out_valid), 0);
    check("held_after_drain", 32'(bus.out_data), 32'h02);
    wait_drain();

    // Reset flush with two buffered entries
    bus.out_ready = 1'b0;
    drive(8'h11, 1'b0, 1'b0, 1'b0);
    drive(8'h22, 1'b0, 1'b0, 1'b0);
    check("flush_full", 32'(bus.in_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 0);
    check("flush_in_ready", 32'(bus.in_ready), 1);
    check("flush_stat", 32'(stat_count), 0);
    bus.out_ready = 1'b1;
    drive(8'h33, 1'b0, 1'b1, 1'b1);
    check("first_after_reset", 32'(bus.out_data), 32'h33);
    drive(8'h81, 1'b1, 1'b1, 1'b1);
    check("neg127_sm", 32'(bus.out_data), 32'hFF);
    check("neg127_unrep", 32'(bus.out_unrep), 0);
    for (int i = 0; i < 4; i++)
      drive(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    wait_drain();

`ifdef SMENC_STATS_EN
    check("stat_final", 32'(stat_count), 3);
`else
    check("stat_final", 32'(stat_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
